// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
// FSM states, grant ids and default widths.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } grant_t;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction at a time, round-robin on ties, bounded wait.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_valid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_valid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                bus_err,
   output logic                stall
);

   localparam int SW    = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arb_state_t        r_state;
   grant_t            r_last;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [SW-1:0]     r_mem_wstrb;
   logic              r_if_valid;
   logic              r_d_valid;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_bus_err;

   logic w_gnt_if;
   logic w_gnt_d;
   logic w_tmo;

   // Fetch wins unless data also asks and fetch was served last.
   assign w_gnt_if = if_req & (~d_req | (r_last == GNT_D));
   assign w_gnt_d  = d_req & ~w_gnt_if;

   // Wait budget exhausted; a zero budget never expires.
   assign w_tmo = (TIMEOUT != 0) && (r_cnt == TO_V);

   assign stall = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wstrb = r_mem_wstrb;
   assign if_valid  = r_if_valid;
   assign if_rdata  = r_if_rdata;
   assign d_valid   = r_d_valid;
   assign d_rdata   = r_d_rdata;
   assign bus_err   = r_bus_err;

   // Grant, hold the latched command, then retire on ready or timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last      <= GNT_D;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_if_valid  <= 1'b0;
         r_d_valid   <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_bus_err   <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         r_bus_err  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_gnt_if) begin
                  r_state     <= BUSY_IF;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_mem_wdata <= '0;
                  r_mem_wstrb <= '0;
                  r_cnt       <= '0;
               end else if (w_gnt_d) begin
                  r_state     <= BUSY_D;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_we;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
                  r_mem_wstrb <= d_wstrb;
                  r_cnt       <= '0;
               end
            end
            BUSY_IF, BUSY_D: begin
               if (mem_ready || w_tmo) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
                  r_bus_err <= ~mem_ready;
                  if (r_state == BUSY_IF) begin
                     r_if_valid <= 1'b1;
                     r_last     <= GNT_IF;
                     r_if_rdata <= mem_ready ? mem_rdata : '0;
                  end else begin
                     r_d_valid <= 1'b1;
                     r_last    <= GNT_D;
                     if (!mem_ready) begin
                        r_d_rdata <= '0;
                     end else if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                     end
                  end
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Vector table, directed corner sequences, random traffic vs model.
module tb_mem_port_arbiter;

   localparam int T  = 4;
   localparam int NR = 1500;

   typedef struct {
      bit          dport;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rd;
      int          w;
      int          exp_vc;
      bit          exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        bus_err;
   logic        stall;

   int total = 0;
   int bad = 0;
   int mw = 0;
   int mcnt = 0;
   bit use_fixed = 1'b1;
   logic [31:0] fixed_rd = '0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h0000A5A5;
   endfunction

   // Memory: ready after mw wait cycles of a held request.
   assign mem_ready = mem_req && (mcnt == mw);
   assign mem_rdata = !mem_ready ? 32'hBAD0BAD0 :
                      (use_fixed ? fixed_rd : memf(mem_addr));

   always @(posedge clk) begin
      if (rst || !mem_req || mem_ready) mcnt <= 0;
      else mcnt <= mcnt + 1;
   end

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_valid(if_valid),
      .if_rdata(if_rdata),
      .d_req(d_req),
      .d_we(d_we),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_wstrb(d_wstrb),
      .d_valid(d_valid),
      .d_rdata(d_rdata),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .bus_err(bus_err),
      .stall(stall)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(bit dp, bit we, logic [31:0] a,
                               logic [31:0] wd, logic [3:0] s,
                               logic [31:0] rd, int w, int vc,
                               bit e, logic [31:0] er);
      vec_t v;
      v.dport = dp; v.we = we; v.addr = a; v.wdata = wd;
      v.strb = s; v.rd = rd; v.w = w; v.exp_vc = vc;
      v.exp_err = e; v.exp_rd = er;
      return v;
   endfunction

   // One isolated transaction; starts and ends 1 after a rising edge.
   task automatic run_one(input int k, input vec_t v);
      int vc;
      int rc;
      logic vld;
      logic [31:0] rd;
      vc = -1;
      rc = -1;
      use_fixed = 1'b1;
      fixed_rd = v.rd;
      mw = v.w;
      if (v.dport) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr;
         d_wdata = v.wdata; d_wstrb = v.strb;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 0; c < 16 && vc < 0; c++) begin
         if (c > 0) nxt();
         #1;
         if (mem_req && rc < 0) begin
            rc = c;
            chk($sformatf("v%0d_addr", k), mem_addr, v.addr);
            chk($sformatf("v%0d_we", k), mem_we, v.we);
            if (v.we) begin
               chk($sformatf("v%0d_wdata", k), mem_wdata, v.wdata);
               chk($sformatf("v%0d_wstrb", k), mem_wstrb, v.strb);
            end
         end
         vld = v.dport ? d_valid : if_valid;
         if (vld) begin
            vc = c;
            rd = v.dport ? d_rdata : if_rdata;
            chk($sformatf("v%0d_err", k), bus_err, v.exp_err);
            chk($sformatf("v%0d_rdata", k), rd, v.exp_rd);
            if_req = 1'b0;
            d_req = 1'b0;
         end
      end
      chk($sformatf("v%0d_latency", k), vc, v.exp_vc);
      chk($sformatf("v%0d_req_cycle", k), rc, 1);
      if_req = 1'b0;
      d_req = 1'b0;
      nxt();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [10];
      int free_at, vc, gcyc, w;
      bit gd, gwe, gerr, last_d, di, dd;
      logic [31:0] ga, gw, eird, edrd;
      logic [3:0] gs;

      tbl[0] = mk(0, 0, 32'h10, 0, 0, 32'h00500093, 0, 2, 0, 32'h00500093);
      tbl[1] = mk(1, 0, 32'h100, 0, 0, 32'h12345678, 0, 2, 0, 32'h12345678);
      tbl[2] = mk(0, 0, 32'h44, 0, 0, 32'h00000013, 2, 4, 0, 32'h00000013);
      tbl[3] = mk(1, 0, 32'h104, 0, 0, 32'h89ABCDEF, 4, 6, 0, 32'h89ABCDEF);
      tbl[4] = mk(1, 0, 32'h108, 0, 0, 32'h11111111, 99, 6, 1, 32'h0);
      tbl[5] = mk(1, 1, 32'h200, 32'h55AA55AA, 4'b1100, 32'h77777777,
                  1, 3, 0, 32'h0);
      tbl[6] = mk(0, 0, 32'h48, 0, 0, 32'h22222222, 7, 6, 1, 32'h0);
      tbl[7] = mk(1, 0, 32'h10C, 0, 0, 32'hCAFEF00D, 1, 3, 0, 32'hCAFEF00D);
      tbl[8] = mk(1, 1, 32'h300, 32'h01020304, 4'b1111, 32'h44444444,
                  0, 2, 0, 32'hCAFEF00D);
      tbl[9] = mk(0, 0, 32'h4C, 0, 0, 32'h33333333, 3, 5, 0, 32'h33333333);

      // Reset held with both ports requesting.
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      use_fixed = 1'b0; mw = 0;
      nxt();
      #1;
      chk("rst_mreq_c1", mem_req, 1'b0);
      nxt();
      #1;
      chk("rst_mreq", mem_req, 1'b0);
      chk("rst_mwe", mem_we, 1'b0);
      chk("rst_maddr", mem_addr, 32'h0);
      chk("rst_mwdata", mem_wdata, 32'h0);
      chk("rst_mwstrb", mem_wstrb, 4'h0);
      chk("rst_ivld", if_valid, 1'b0);
      chk("rst_dvld", d_valid, 1'b0);
      chk("rst_irdata", if_rdata, 32'h0);
      chk("rst_drdata", d_rdata, 32'h0);
      chk("rst_berr", bus_err, 1'b0);
      rst = 1'b0;
      chk("tie_stall0", stall, 1'b1);

      // Continuous tie: fetch first, then alternate.
      for (int c = 1; c <= 9; c++) begin
         nxt();
         #1;
         chk("tie_mreq", mem_req, (c % 2 == 1) && (c < 9));
         if (c % 2 == 1 && c < 9)
            chk("tie_addr", mem_addr, (c % 4 == 1) ? 32'h20 : 32'h100);
         chk("tie_ivld", if_valid, c == 2 || c == 6);
         chk("tie_dvld", d_valid, c == 4 || c == 8);
         if (c == 2) chk("tie_irdata", if_rdata, memf(32'h20));
         if (c == 4) chk("tie_drdata", d_rdata, memf(32'h100));
         if (c < 8) chk("tie_stall", stall, 1'b1);
         if (c == 8) begin
            if_req = 1'b0;
            d_req = 1'b0;
         end
      end
      nxt();

      for (int k = 0; k < 10; k++) run_one(k, tbl[k]);

      // Store with waits: command must not follow toggling inputs.
      use_fixed = 1'b1; fixed_rd = 32'hFFFFFFFF; mw = 3;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100;
      d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
      #1;
      chk("st_stall0", stall, 1'b1);
      for (int c = 1; c <= 5; c++) begin
         nxt();
         if (c < 5) begin
            d_addr = $urandom; d_wdata = $urandom;
            d_wstrb = 4'($urandom); d_we = ~d_we;
         end else begin
            d_req = 1'b0;
         end
         #1;
         if (c < 5) begin
            chk("st_mreq", mem_req, 1'b1);
            chk("st_addr", mem_addr, 32'h100);
            chk("st_we", mem_we, 1'b1);
            chk("st_wdata", mem_wdata, 32'hDEADBEEF);
            chk("st_wstrb", mem_wstrb, 4'b0011);
            chk("st_dvld_early", d_valid, 1'b0);
            chk("st_stall", stall, 1'b1);
         end else begin
            chk("st_dvld", d_valid, 1'b1);
            chk("st_berr", bus_err, 1'b0);
            chk("st_drdata", d_rdata, 32'hCAFEF00D);
            chk("st_mreq_done", mem_req, 1'b0);
         end
      end
      nxt();

      // Load timeout with a fetch queued behind it.
      mw = 99; fixed_rd = 32'h0BADF00D;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) nxt();
         if (c == 2) begin
            if_req = 1'b1;
            if_addr = 32'h60;
         end
         if (c == 6) begin
            d_req = 1'b0;
            mw = 0;
         end
         if (c == 8) if_req = 1'b0;
         #1;
         chk("to_dvld", d_valid, c == 6);
         chk("to_berr", bus_err, c == 6);
         chk("to_mreq", mem_req, (c >= 1 && c <= 5) || c == 7);
         if (c == 6) chk("to_drdata", d_rdata, 32'h0);
         if (c == 7) chk("to_next_addr", mem_addr, 32'h60);
         if (c == 8) begin
            chk("to_ivld", if_valid, 1'b1);
            chk("to_irdata", if_rdata, 32'h0BADF00D);
         end
      end
      nxt();

      // Reset while fetch outstanding, then fetch wins the next tie.
      mw = 99;
      if_req = 1'b1; if_addr = 32'h70;
      for (int c = 0; c <= 13; c++) begin
         if (c > 0) nxt();
         if (c == 2) begin
            rst = 1'b1;
            if_req = 1'b0;
         end
         if (c == 3) rst = 1'b0;
         if (c == 9) begin
            mw = 0;
            if_req = 1'b1; if_addr = 32'h74;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
         end
         if (c == 11) if_req = 1'b0;
         if (c == 13) d_req = 1'b0;
         #1;
         chk("rb_mreq", mem_req, c == 1 || c == 2 || c == 10 || c == 12);
         chk("rb_ivld", if_valid, c == 11);
         chk("rb_dvld", d_valid, c == 13);
         if (c == 10) chk("rb_first_addr", mem_addr, 32'h74);
         if (c == 12) chk("rb_second_addr", mem_addr, 32'h104);
      end
      nxt();

      // Random traffic against a transaction-level timing model.
      rst = 1'b1;
      nxt();
      nxt();
      rst = 1'b0;
      use_fixed = 1'b0;
      free_at = 0; vc = -1; gcyc = -10; last_d = 1'b1;
      eird = '0; edrd = '0;
      gd = 0; gwe = 0; gerr = 0; ga = '0; gw = '0; gs = '0;
      for (int c = 0; c < NR; c++) begin
         if (c > 0) nxt();
         di = (vc == c) && !gd;
         dd = (vc == c) && gd;
         if (vc == c) begin
            if (gerr) begin
               if (gd) edrd = '0;
               else eird = '0;
            end else if (!gd) begin
               eird = memf(ga);
            end else if (!gwe) begin
               edrd = memf(ga);
            end
         end
         if (!if_req || di) begin
            if_req = (c < NR - 24) && ($urandom_range(0, 3) != 0);
            if_addr = $urandom & 32'hFFFFFFFC;
         end
         if (!d_req || dd) begin
            d_req = (c < NR - 24) && ($urandom_range(0, 3) != 0);
            d_we = 1'($urandom);
            d_addr = $urandom & 32'hFFFFFFFC;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
         end
         #1;
         chk("rnd_mreq", mem_req, c > gcyc && c < vc);
         if (c > gcyc && c < vc) begin
            chk("rnd_addr", mem_addr, ga);
            chk("rnd_we", mem_we, gwe);
            if (gwe) begin
               chk("rnd_wdata", mem_wdata, gw);
               chk("rnd_wstrb", mem_wstrb, gs);
            end
         end
         chk("rnd_ivld", if_valid, di);
         chk("rnd_dvld", d_valid, dd);
         chk("rnd_berr", bus_err, (di | dd) & gerr);
         chk("rnd_irdata", if_rdata, eird);
         chk("rnd_drdata", d_rdata, edrd);
         chk("rnd_stall", stall, (if_req & ~di) | (d_req & ~dd));
         if (c >= free_at && (if_req || d_req)) begin
            gd = d_req && (!if_req || !last_d);
            last_d = gd;
            ga = gd ? d_addr : if_addr;
            gwe = gd ? d_we : 1'b0;
            gw = d_wdata;
            gs = d_wstrb;
            w = $urandom_range(0, 6);
            mw = w;
            gerr = (w > T);
            gcyc = c;
            vc = c + 2 + (gerr ? T : w);
            free_at = vc;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port to one-port memory arbiter that lets the instruction-fetch path and the load/store path share a single unified memory port. It sits between the core's fetch/LSU request interfaces and the memory model. It sequences one memory transaction at a time through a small FSM and raises `stall` so the core holds its PC and pipeline state while a request is outstanding. A wait-cycle timeout bounds each transaction.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, maximum wait cycles for `mem_ready` per transaction; 0 disables the timeout

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch request; level signal
- `if_addr`  in  ADDR_W  fetch address
- `if_valid`  out  1  one-cycle pulse: fetch complete
- `if_rdata`  out  DATA_W  fetched instruction; valid with `if_valid`
- `d_req`  in  1  data request; level signal
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  byte enables for stores
- `d_valid`  out  1  one-cycle pulse: data access complete
- `d_rdata`  out  DATA_W  load data; valid with `d_valid`
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  memory command
- `mem_ready`  in  1  memory done; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  DATA_W  memory read data
- `bus_err`  out  1  one-cycle pulse together with `if_valid`/`d_valid` when a timeout ends the transaction
- `stall`  out  1  combinational: `(if_req & ~if_valid) | (d_req & ~d_valid)`

## Operation
- FSM states: `IDLE`, `BUSY_IF`, `BUSY_D`. Reset puts the FSM in `IDLE`.
- In `IDLE`, a request with no competitor is granted immediately. The command (addr, we, wdata, wstrb) is latched into registers, and the FSM moves to the matching `BUSY_*` state.
- Simultaneous requests use round-robin: grant the port not served last. `last_grant` resets to data, so fetch wins the first tie.
- In `BUSY_*`:
  - `mem_req` is 1 and all `mem_*` command outputs are taken from the latched registers. They stay stable regardless of changes on the requester inputs.
- On `mem_ready`:
  - Capture `mem_rdata` into `if_rdata` (fetch) or `d_rdata` (load only). A store leaves `d_rdata` unchanged.
  - Next cycle: pulse the port's `valid`, deassert `mem_req`, return to `IDLE`, update `last_grant`.
- A requester holds `req` and its payload until its `valid`. A `req` still high in the cycle its `valid` is asserted is treated as a new transaction. This gives back-to-back issue.
- Timeout: a wait counter clears on entry to `BUSY_*` and increments each `BUSY` cycle without `mem_ready`. When `TIMEOUT != 0` and the counter reaches `TIMEOUT`:
  - Next cycle: pulse `valid` + `bus_err`, rdata = 0, return to `IDLE`.
  - `mem_ready` arriving in the same cycle as the timeout wins; no error is raised.
- Reset mid-transaction: the FSM returns to `IDLE` at the reset edge with no `valid` pulse. The memory tolerates request withdrawal.

## Timing
- Reset values: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `if_valid`, `d_valid`, `if_rdata`, `d_rdata`, `bus_err` are all 0.
- All outputs except `stall` are registered.
- Minimum latency, `mem_ready` tied high:
  - `req` in cycle N → `mem_req` in N+1 → `valid` in N+2.
  - Back-to-back sustained throughput: one transaction per 2 cycles.
- Memory wait W cycles (`mem_ready` in cycle N+1+W) → `valid` in N+2+W.
- Counter width: `$clog2(TIMEOUT+1)`. Saturating; no wrap-around.

## Structure
- `mem_arb_pkg`: state enum `arb_state_t` (`IDLE`, `BUSY_IF`, `BUSY_D`), grant enum `grant_t` (`GNT_IF`, `GNT_D`), default width constants.
- Single module. The round-robin and timeout logic are small enough to stay inline; no sub-module.

## Test plan
1. Reset: `rst`=1 for 2 cycles with both `req` high → all registered outputs 0, `mem_req`=0 during reset, fetch granted first after release.
2. Single fetch, `mem_ready`=1, `if_addr`=0x10, `mem_rdata`=0x00500093 → `mem_req`+`mem_addr`=0x10 in cycle 1; `if_valid`, `if_rdata`=0x00500093 in cycle 2; `stall` high in cycles 0–1.
3. Tie: both `req` in cycle 0 (`if_addr`=0x20, `d_addr`=0x100, load) → memory sees 0x20 then 0x100. A repeated tie afterwards alternates grants D, IF.
4. Store `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_wstrb`=4'b0011, `mem_ready` after 3 wait cycles → `mem_*` stable for 4 cycles while inputs toggle; `d_valid` in cycle 5; `d_rdata` unchanged.
5. `TIMEOUT`=4, `mem_ready` held 0 → `d_valid`+`bus_err` one cycle after the counter reaches 4, `d_rdata`=0, then the pending fetch is served.
6. `rst` asserted in `BUSY_IF` → next edge `mem_req`=0, no `if_valid`; FSM idle.
